// File: rtl/fifo_rd_pkg.sv
// Shared constants and state encoding for the FIFO read-side burst controller.
// Pure declarations, no logic and no latency.
// Backpressure behaviour is defined by the modules that import this package.
package fifo_rd_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int BURST_LEN_MAX = 8;
    // Burst counter must hold BURST_LEN_MAX itself
    localparam int BCNT_W        = $clog2(BURST_LEN_MAX + 1);

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry in-order valid/ready buffer between FIFO capture and the consumer.
// Latency: a pushed word is visible on head_data/head_valid the cycle after the push.
// Backpressure: no push_ready; the producer must keep occupancy + in-flight <= 2.
module rd_skid_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] head_data,
    output logic              head_valid,
    input  logic              head_ready,
    output logic [1:0]        occupancy
);

    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] tail;
    logic [1:0]        occ;
    logic              pop;

    assign pop        = head_valid && head_ready;
    assign head_data  = head;
    assign head_valid = (occ != 2'd0);
    assign occupancy  = occ;

    // Head only changes on a pop or on a push into an empty buffer, so it holds while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            occ  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= push_data;
                    else             tail <= push_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// FIFO read-side controller: burst reads when >=8 words stored, paced drain on flush.
// Latency: r_en the cycle after the burst decision; word on m_valid 2 edges after its r_en edge.
// Backpressure: r_en only while buffer occupancy + in-flight (minus this cycle's pop) < 2.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_LEN = BURST_LEN_MAX,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              empty_flag,
    input  logic              almost_empty,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              flush,
    output logic              r_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              burst_active,
    output logic              flush_done,
    output logic [CNT_W-1:0]  rd_count
);

    state_t            state;
    state_t            state_nxt;
    logic [BCNT_W-1:0] burst_cnt;
    logic              in_flight;
    logic              flush_pend;
    logic              go_burst;
    logic              go_flush;
    logic              flush_exit;
    logic [1:0]        occupancy;
    logic [2:0]        used;
    logic              credit_ok;

    // A word leaving the buffer this cycle frees its slot now, giving 1 word/cycle in a burst
    assign used      = {1'b0, occupancy} + {2'b00, in_flight} - {2'b00, m_valid && m_ready};
    assign credit_ok = (used < 3'd2);

    assign burst_active = (state != ST_IDLE);

    // in_flight also serves as the flush gap timer: it is high exactly the cycle after a read,
    // which is the cycle the FIFO flags still show the pre-read pointer
    always_comb begin
        state_nxt  = state;
        r_en       = 1'b0;
        go_burst   = 1'b0;
        go_flush   = 1'b0;
        flush_exit = 1'b0;
        case (state)
            ST_IDLE: begin
                // Decide only once the flags reflect the last read
                if (!in_flight) begin
                    if (flush_pend) begin
                        state_nxt = ST_FLUSH;
                        go_flush  = 1'b1;
                    end else if (!almost_empty) begin
                        state_nxt = ST_BURST;
                        go_burst  = 1'b1;
                    end
                end
            end
            ST_BURST: begin
                r_en = credit_ok;
                if (credit_ok && burst_cnt == BCNT_W'(1)) state_nxt = ST_IDLE;
            end
            ST_FLUSH: begin
                r_en = credit_ok && !empty_flag && !(almost_empty && in_flight);
                if (empty_flag && !in_flight && occupancy == 2'd0) begin
                    state_nxt  = ST_IDLE;
                    flush_exit = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM, burst counter, in-flight bit, flush request latch and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            burst_cnt  <= '0;
            in_flight  <= 1'b0;
            flush_pend <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_flight  <= r_en;
            flush_done <= flush_exit;
            if (go_burst)
                burst_cnt <= BCNT_W'(BURST_LEN);
            else if (state == ST_BURST && r_en)
                burst_cnt <= burst_cnt - BCNT_W'(1);
            // A flush seen while already flushing is absorbed into the current drain
            if (go_flush)
                flush_pend <= 1'b0;
            else if (flush && state != ST_FLUSH)
                flush_pend <= 1'b1;
        end
    end

    // Delivered-word counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_count <= '0;
        else if (m_valid && m_ready)
            rd_count <= rd_count + CNT_W'(1);
    end

    // The word read at edge N is on fifo_data after N and is captured at N+1
    rd_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (in_flight),
        .push_data  (fifo_data),
        .head_data  (m_data),
        .head_valid (m_valid),
        .head_ready (m_ready),
        .occupancy  (occupancy)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

    localparam int DW  = 8;
    localparam int CW  = 16;
    localparam int TOT = 65536 + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          empty_flag = 1'b1;
    logic          almost_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          flush = 1'b0;
    logic          r_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          burst_active;
    logic          flush_done;
    logic [CW-1:0] rd_count;

    int errors = 0;
    int checks = 0;

    fifo_burst_reader #(
        .DATA_W    (DW),
        .BURST_LEN (8),
        .CNT_W     (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .empty_flag   (empty_flag),
        .almost_empty (almost_empty),
        .fifo_data    (fifo_data),
        .flush        (flush),
        .r_en         (r_en),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .burst_active (burst_active),
        .flush_done   (flush_done),
        .rd_count     (rd_count)
    );

    always #5 clk = ~clk;

    // FIFO model: read data valid after the read edge, flags lag the pointer by one edge
    logic [7:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    always @(posedge clk) begin
        if (r_en && !empty_flag) begin
            fifo_data <= mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
        empty_flag   <= ((wr_ptr - rd_ptr) == 0);
        almost_empty <= ((wr_ptr - rd_ptr) < 8);
    end

    // Event log: reads, deliveries, done pulses, reads against an empty FIFO
    int cyc = 0;
    int fd_cnt = 0;
    int viol = 0;
    int got[$];
    int got_cyc[$];
    int ren_cyc[$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (r_en) ren_cyc.push_back(cyc);
        if (r_en && (empty_flag || wr_ptr == rd_ptr)) viol <= viol + 1;
        if (m_valid && m_ready) begin
            got.push_back(int'(m_data));
            got_cyc.push_back(cyc);
        end
        if (flush_done) fd_cnt <= fd_cnt + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        wr_ptr  = rd_ptr;
        tick(3);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic load(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[7:0]] = 8'(first + i);
            wr_ptr++;
        end
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
    endtask

    function automatic int seq_bad(input int base, input int n, input int first);
        int b = 0;
        for (int i = 0; i < n; i++)
            if (base + i >= got.size() || got[base + i] != ((first + i) & 255)) b++;
        return b;
    endfunction

    function automatic int rc(input int i);
        return (i < ren_cyc.size()) ? ren_cyc[i] : -1000;
    endfunction

    function automatic int gc(input int i);
        return (i < got_cyc.size()) ? got_cyc[i] : -1000;
    endfunction

    initial begin
        int g0, r0, f0, v0, nrd, base, mg, written, expn;

        // Reset state
        @(negedge clk);
        check("rst_r_en", int'(r_en), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_burst_active", int'(burst_active), 0);
        check("rst_flush_done", int'(flush_done), 0);
        check("rst_rd_count", int'(rd_count), 0);

        // 20 words, free-running consumer: two bursts of 8, 4 left
        do_reset();
        m_ready = 1'b1;
        g0 = got.size(); r0 = ren_cyc.size(); v0 = viol;
        load(1, 20);
        for (int i = 0; i < 300 && (got.size() - g0) < 16; i++) tick(1);
        tick(30);
        check("t1_count", got.size() - g0, 16);
        check("t1_order", seq_bad(g0, 16, 1), 0);
        check("t1_ren_run1", rc(r0 + 7) - rc(r0), 7);
        check("t1_ren_run2", rc(r0 + 15) - rc(r0 + 8), 7);
        check("t1_latency", gc(g0) - rc(r0), 2);
        check("t1_deliv_run", gc(g0 + 7) - gc(g0), 7);
        check("t1_reads", ren_cyc.size() - r0, 16);
        check("t1_left", wr_ptr - rd_ptr, 4);
        check("t1_idle", int'(burst_active), 0);
        check("t1_viol", viol - v0, 0);

        // Consumer stall mid-burst for 10 cycles
        do_reset();
        m_ready = 1'b1;
        g0 = got.size(); r0 = ren_cyc.size();
        load(1, 20);
        for (int i = 0; i < 100 && (got.size() - g0) < 3; i++) tick(1);
        m_ready = 1'b0;
        tick(1);
        check("t2_head_early", int'(m_data), 4);
        tick(9);
        check("t2_head_late", int'(m_data), 4);
        check("t2_valid", int'(m_valid), 1);
        check("t2_r_en_low", int'(r_en), 0);
        check("t2_outstanding", (ren_cyc.size() - r0) - (got.size() - g0), 2);
        m_ready = 1'b1;
        for (int i = 0; i < 300 && (got.size() - g0) < 16; i++) tick(1);
        tick(20);
        check("t2_count", got.size() - g0, 16);
        check("t2_order", seq_bad(g0, 16, 1), 0);

        // Flush with 5 words stored
        do_reset();
        m_ready = 1'b1;
        g0 = got.size(); r0 = ren_cyc.size(); f0 = fd_cnt; v0 = viol;
        load(101, 5);
        tick(3);
        pulse_flush();
        for (int i = 0; i < 100 && fd_cnt == f0; i++) tick(1);
        tick(20);
        mg = 1000;
        for (int i = r0; i + 1 < ren_cyc.size(); i++)
            if (ren_cyc[i + 1] - ren_cyc[i] < mg) mg = ren_cyc[i + 1] - ren_cyc[i];
        check("t3_done_pulses", fd_cnt - f0, 1);
        check("t3_count", got.size() - g0, 5);
        check("t3_order", seq_bad(g0, 5, 101), 0);
        check("t3_reads", ren_cyc.size() - r0, 5);
        check("t3_gap_ge2", int'(mg >= 2), 1);
        check("t3_viol", viol - v0, 0);
        check("t3_idle", int'(burst_active), 0);

        // Flush during a burst with 12 stored, second flush while draining
        do_reset();
        m_ready = 1'b1;
        g0 = got.size(); r0 = ren_cyc.size(); f0 = fd_cnt; v0 = viol;
        load(1, 12);
        for (int i = 0; i < 50 && (ren_cyc.size() - r0) < 2; i++) tick(1);
        pulse_flush();
        for (int i = 0; i < 100 && (ren_cyc.size() - r0) < 10; i++) tick(1);
        pulse_flush();
        for (int i = 0; i < 200 && fd_cnt == f0; i++) tick(1);
        tick(30);
        check("t4_done_pulses", fd_cnt - f0, 1);
        check("t4_count", got.size() - g0, 12);
        check("t4_order", seq_bad(g0, 12, 1), 0);
        check("t4_reads", ren_cyc.size() - r0, 12);
        check("t4_burst_run", rc(r0 + 7) - rc(r0), 7);
        check("t4_rd_count", int'(rd_count), 12);
        check("t4_viol", viol - v0, 0);

        // Reset while a read is in flight
        do_reset();
        m_ready = 1'b1;
        r0 = ren_cyc.size();
        base = rd_ptr;
        load(1, 20);
        for (int i = 0; i < 50 && (ren_cyc.size() - r0) < 3; i++) tick(1);
        rst_n = 1'b0;
        nrd = rd_ptr - base;
        #1;
        check("t5_r_en", int'(r_en), 0);
        check("t5_m_valid", int'(m_valid), 0);
        check("t5_m_data", int'(m_data), 0);
        check("t5_burst_active", int'(burst_active), 0);
        check("t5_flush_done", int'(flush_done), 0);
        check("t5_rd_count", int'(rd_count), 0);
        tick(2);
        rst_n = 1'b1;
        g0 = got.size();
        expn = ((20 - nrd) / 8) * 8;
        for (int i = 0; i < 300 && (got.size() - g0) < expn; i++) tick(1);
        tick(30);
        check("t5_count", got.size() - g0, expn);
        check("t5_order", seq_bad(g0, expn, nrd + 1), 0);
        check("t5_deliv_run", gc(g0 + 7) - gc(g0), 7);

        // rd_count wrap after 2^16+3 deliveries
        do_reset();
        m_ready = 1'b1;
        g0 = got.size(); f0 = fd_cnt;
        written = 0;
        for (int c = 0; c < 95000 && written < TOT; c++) begin
            tick(1);
            if (wr_ptr - rd_ptr < 200) begin
                mem[wr_ptr[7:0]] = 8'(written);
                wr_ptr++;
                written++;
            end
        end
        for (int i = 0; i < 400 && ((wr_ptr - rd_ptr) >= 8 || burst_active); i++) tick(1);
        tick(4);
        pulse_flush();
        for (int i = 0; i < 200 && fd_cnt == f0; i++) tick(1);
        tick(5);
        check("t6_delivered", got.size() - g0, TOT);
        check("t6_order", seq_bad(g0, TOT, 0), 0);
        check("t6_rd_count", int'(rd_count), 3);
        check("t6_fifo_empty", wr_ptr - rd_ptr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
